// File: rtl/xup_tri_bus_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
// Holds the FSM state enum and the round-robin pick function.
package xup_tri_bus_pkg;

  localparam int MAXN = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  // First set bit searching ptr, ptr+1, ... wrapping at n.
  function automatic int unsigned rr_pick(
    input logic [MAXN-1:0] req,
    input int unsigned     ptr,
    input int unsigned     n
  );
    int unsigned j;
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAXN; k++) begin
      if (k < n && !found) begin
        j = (ptr + k) % n;
        if (req[j[3:0]]) begin
          found = 1'b1;
          idx   = j;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/xup_rr_picker.sv
// Combinational round-robin priority select.
// Returns the winning index and whether any request is set.
module xup_rr_picker
  import xup_tri_bus_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  localparam int IW = $clog2(NUM_REQ);

  int unsigned w_pick;

  assign w_pick  = rr_pick(MAXN'(i_req), 32'(i_ptr), NUM_REQ);
  assign o_idx   = IW'(w_pick);
  assign o_valid = |i_req;

endmodule

// File: rtl/xup_tri_bus_arbiter.sv
// Round-robin tri-state bus arbiter with turnaround gap
// and a per-ownership hold limit.
module xup_tri_bus_arbiter
  import xup_tri_bus_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         bus_en,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW =
    (MAX_HOLD < 2) ? 2 : $clog2(MAX_HOLD + 1);
  localparam int TW =
    (TURNAROUND < 2) ? 1 : $clog2(TURNAROUND + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_SAT = '1;
  localparam logic [TW-1:0] TURN_LIM = TW'(TURNAROUND);

  state_t               r_state, w_state;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic [NUM_REQ-1:0]   r_bus_en, w_bus_en;
  logic [IW-1:0]        r_owner, w_owner;
  logic [IW-1:0]        r_ptr, w_ptr;
  logic [HW-1:0]        r_hold, w_hold;
  logic [TW-1:0]        r_turn, w_turn;
  logic [IW-1:0]        w_win;
  logic                 w_valid;
  logic [IW-1:0]        w_win_inc;
  logic                 w_release;

  xup_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_idx   (w_win),
    .o_valid (w_valid)
  );

  assign w_win_inc = (w_win == IW'(NUM_REQ - 1))
                   ? '0 : w_win + 1'b1;

  assign w_release = !req[r_owner] ||
    ((MAX_HOLD != 0) && (r_hold == HOLD_LIM));

  // Next-state and next-output decode for the bus FSM.
  always_comb begin
    w_state  = r_state;
    w_gnt    = r_gnt;
    w_bus_en = r_bus_en;
    w_owner  = r_owner;
    w_ptr    = r_ptr;
    w_hold   = r_hold;
    w_turn   = r_turn;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state  = GRANT;
          w_gnt    = NUM_REQ'(1) << w_win;
          w_bus_en = NUM_REQ'(1) << w_win;
          w_owner  = w_win;
          w_ptr    = w_win_inc;
          w_hold   = HW'(1);
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state  = TURN;
          w_gnt    = '0;
          w_bus_en = '0;
          w_turn   = TW'(1);
        end else if (r_hold != HOLD_SAT) begin
          w_hold = r_hold + 1'b1;
        end
      end
      TURN: begin
        if (r_turn == TURN_LIM) begin
          w_state = IDLE;
        end else begin
          w_turn = r_turn + 1'b1;
        end
      end
      default: begin
        w_state  = IDLE;
        w_gnt    = '0;
        w_bus_en = '0;
      end
    endcase
  end

  // State and output registers; reset floats the bus at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_bus_en <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_turn   <= '0;
    end else begin
      r_state  <= w_state;
      r_gnt    <= w_gnt;
      r_bus_en <= w_bus_en;
      r_owner  <= w_owner;
      r_ptr    <= w_ptr;
      r_hold   <= w_hold;
      r_turn   <= w_turn;
    end
  end

  assign gnt      = r_gnt;
  assign bus_en   = r_bus_en;
  assign busy     = (r_state != IDLE);
  assign owner_id = r_owner;

endmodule

// File: tb/tb_xup_tri_bus_arbiter.sv
// Bench for xup_tri_bus_arbiter: hold-limited and unlimited
// instances checked against a gap/run-length bus model.
module tb_xup_tri_bus_arbiter;

  localparam int N  = 4;
  localparam int TA = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b1111;
  logic [3:0] gA, beA, gB, beB;
  logic       bA, bB;
  logic [1:0] oA, oB;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  int         MH [2] = '{4, 0};
  logic [3:0] m_gnt [2];
  int         m_own [2];
  int         m_ptr [2];
  int         m_run [2];
  int         m_since [2];

  always #5 clk = ~clk;

  xup_tri_bus_arbiter #(
    .NUM_REQ(4), .TURNAROUND(1), .MAX_HOLD(4)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gA), .bus_en(beA), .busy(bA), .owner_id(oA)
  );

  xup_tri_bus_arbiter #(
    .NUM_REQ(4), .TURNAROUND(1), .MAX_HOLD(0)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gB), .bus_en(beB), .busy(bB), .owner_id(oB)
  );

  task automatic check(input string name,
                       input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r,
                              input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_gnt[i]   = 4'b0;
      m_own[i]   = 0;
      m_ptr[i]   = 0;
      m_run[i]   = 0;
      m_since[i] = TA;
    end
  endtask

  // m_since counts edges since the bus was released.
  task automatic m_step(input logic [3:0] r);
    int w;
    for (int i = 0; i < 2; i++) begin
      if (m_gnt[i] != 0) begin
        if (!r[m_own[i]] ||
            (MH[i] != 0 && m_run[i] == MH[i])) begin
          m_gnt[i]   = 4'b0;
          m_since[i] = 0;
        end else begin
          m_run[i]++;
        end
      end else if (m_since[i] >= TA && r != 0) begin
        w        = pick(r, m_ptr[i]);
        m_own[i] = w;
        m_gnt[i] = 4'(1 << w);
        m_ptr[i] = (w + 1) % N;
        m_run[i] = 1;
      end else if (m_since[i] < TA) begin
        m_since[i]++;
      end
    end
  endtask

  function automatic int m_busy(input int i);
    return int'(m_gnt[i] != 0 || m_since[i] < TA);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("A.gnt", gA, m_gnt[0]);
      check("A.bus_en", beA, m_gnt[0]);
      check("A.busy", bA, m_busy(0));
      check("A.owner", oA, m_own[0]);
      check("A.onehot0", int'($onehot0(beA)), 1);
      check("B.gnt", gB, m_gnt[1]);
      check("B.bus_en", beB, m_gnt[1]);
      check("B.busy", bB, m_busy(1));
      check("B.owner", oB, m_own[1]);
      check("B.onehot0", int'($onehot0(beB)), 1);
    end
  end

  task automatic cyc(input logic [3:0] r);
    req = r;
    @(posedge clk);
    if (reset_n) m_step(r);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_reset();
    cyc(4'b0000);
    cyc(4'b0000);
    reset_n = 1'b1;
  endtask

  logic [3:0] r;
  int         e;

  initial begin
    m_reset();
    chk_en = 1'b1;
    repeat (3) cyc(4'b1111);
    check("rst.gnt", gA, 0);
    check("rst.bus_en", beA, 0);
    check("rst.busy", bA, 0);
    check("rst.owner", oA, 0);
    reset_n = 1'b1;

    cyc(4'b1111);
    check("first.gnt", gA, 1);
    check("first.owner", oA, 0);
    for (int t = 1; t < 24; t++) begin
      cyc(4'b1111);
      e = (t % 6 < 4) ? (1 << ((t / 6) % 4)) : 0;
      check("rr.gnt", gA, e);
      check("rr.unl", gB, 1);
    end

    repeat (4) cyc(4'b0000);
    for (int t = 0; t < 3; t++) begin
      cyc(4'b0100);
      check("single.gnt", gA, 4);
      check("single.gntB", gB, 4);
    end
    cyc(4'b0000);
    check("single.turn_en", beA, 0);
    check("single.turn_busy", bA, 1);
    cyc(4'b0000);
    check("single.idle_busy", bA, 0);
    check("single.owner", oA, 2);

    cyc(4'b0010);
    check("sole.first", gA, 2);
    for (int t = 1; t < 14; t++) begin
      cyc(4'b0010);
      e = (t % 6 < 4) ? 2 : 0;
      check("sole.gnt", gA, e);
      check("sole.owner", oA, 1);
      check("sole.unl", gB, 2);
    end

    do_reset();
    for (int t = 0; t < 8; t++) begin
      cyc(4'b1001);
      check("unl.keep", gB, 1);
    end
    cyc(4'b1000);
    check("unl.gap1", beB, 0);
    cyc(4'b1000);
    check("unl.gap2", beB, 0);
    cyc(4'b1000);
    check("unl.next", gB, 8);

    r = 4'b0000;
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      cyc(r);
    end

    do_reset();
    cyc(4'b0100);
    check("async.pre", gA, 4);
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    check("async.bus_enA", beA, 0);
    check("async.bus_enB", beB, 0);
    check("async.gnt", gA, 0);
    check("async.busy", bA, 0);
    cyc(4'b0100);
    reset_n = 1'b1;
    repeat (12) cyc(4'b0100);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
